// File: rtl/team_id_mailbox_if.sv
// Peripheral-bus and consumer handshake bundle for the team/key ID mailbox.
// The master side drives the openMSP430 bus and the acknowledge; the slave side is the mailbox.
interface team_id_mailbox_if #(
  parameter int NUM_SLOTS = 4
);
  logic [13:0]             per_addr;
  logic [15:0]             per_din;
  logic                    per_en;
  logic [1:0]              per_we;
  logic                    smclk_en;
  logic                    upd_ack;
  logic [15:0]             per_dout;
  logic [16*NUM_SLOTS-1:0] id_out;
  logic                    upd_req;
  logic                    irq;

  modport master (
    output per_addr, per_din, per_en, per_we, smclk_en, upd_ack,
    input  per_dout, id_out, upd_req, irq
  );

  modport slave (
    input  per_addr, per_din, per_en, per_we, smclk_en, upd_ack,
    output per_dout, id_out, upd_req, irq
  );
endinterface

// File: rtl/team_id_mailbox.sv
// Multi-slot team/key ID mailbox: staging registers committed atomically to a
// shadow bank, with a four-phase req/ack notification to the app-side consumer.
module team_id_mailbox #(
  parameter logic [14:0] BASE_ADDR = 15'h01B0,
  parameter int          DEC_WD    = 3,
  parameter int          NUM_SLOTS = 4
) (
  input logic              mclk,
  input logic              puc_rst,
  team_id_mailbox_if.slave bus
);
  localparam logic [DEC_WD-1:0] CTRL_OFF = DEC_WD'(NUM_SLOTS);
  localparam logic [DEC_WD-1:0] STAT_OFF = DEC_WD'(NUM_SLOTS + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [15:0]             stage [NUM_SLOTS];
  logic [16*NUM_SLOTS-1:0] stage_flat;
  logic [16*NUM_SLOTS-1:0] id_q;
  logic                    locked;
  logic                    ie;
  logic                    ovr;
  logic                    ifg;
  logic [7:0]              cnt;
  logic                    upd_req;
  logic                    busy;
  logic [15:0]             dout;

  logic                    sel;
  logic [DEC_WD-1:0]       offset;
  logic                    wr;
  logic                    rd;
  logic                    ctrl_wr;
  logic                    stat_wr;
  logic                    commit_req;
  logic                    commit_ok;
  logic                    ovr_set;
  logic                    ifg_set;
  logic                    unused_smclk;

  assign unused_smclk = bus.smclk_en;

  assign sel    = bus.per_en & (bus.per_addr[13:DEC_WD] == BASE_ADDR[14:DEC_WD+1]);
  assign offset = bus.per_addr[DEC_WD-1:0];
  assign wr     = sel & (|bus.per_we);
  assign rd     = sel & ~(|bus.per_we);

  assign ctrl_wr    = wr & (offset == CTRL_OFF) & bus.per_we[0];
  assign stat_wr    = wr & (offset == STAT_OFF) & bus.per_we[0];
  assign commit_req = ctrl_wr & bus.per_din[0];
  // Commit decisions use LOCKED as it was before this write, so COMMIT|LOCK still commits.
  assign commit_ok  = commit_req & ~locked & (state == IDLE);
  assign ovr_set    = commit_req & ~locked & (state != IDLE);
  assign ifg_set    = (state == DONE) & ~bus.upd_ack;

  always_comb begin
    stage_flat = '0;
    for (int k = 0; k < NUM_SLOTS; k++) stage_flat[16*k +: 16] = stage[k];
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      for (int k = 0; k < NUM_SLOTS; k++) stage[k] <= '0;
    end else if (wr && !locked) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (offset == DEC_WD'(k)) begin
          if (bus.per_we[0]) stage[k][7:0]  <= bus.per_din[7:0];
          if (bus.per_we[1]) stage[k][15:8] <= bus.per_din[15:8];
        end
      end
    end
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      id_q   <= '0;
      cnt    <= '0;
      locked <= 1'b0;
      ie     <= 1'b0;
      ovr    <= 1'b0;
      ifg    <= 1'b0;
    end else begin
      if (commit_ok) begin
        id_q <= stage_flat;
        cnt  <= cnt + 8'd1;
      end
      if (ctrl_wr) begin
        if (bus.per_din[1]) locked <= 1'b1;
        ie <= bus.per_din[2];
      end
      if (ovr_set)                        ovr <= 1'b1;
      else if (stat_wr && bus.per_din[2]) ovr <= 1'b0;
      // A handshake completing in the same cycle as a W1C keeps the flag set.
      if (ifg_set)                        ifg <= 1'b1;
      else if (stat_wr && bus.per_din[3]) ifg <= 1'b0;
    end
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (commit_ok)     state_nxt = REQ;
      REQ:     if (bus.upd_ack)   state_nxt = DONE;
      DONE:    if (!bus.upd_ack)  state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    upd_req = (state == REQ);
    busy    = (state != IDLE);
  end

  always_comb begin
    dout = '0;
    if (rd) begin
      for (int k = 0; k < NUM_SLOTS; k++)
        if (offset == DEC_WD'(k)) dout = stage[k];
      if (offset == CTRL_OFF) dout = {13'b0, ie, locked, 1'b0};
      if (offset == STAT_OFF) dout = {cnt, 4'b0, ifg, ovr, locked, busy};
    end
  end

  assign bus.per_dout = dout;
  assign bus.id_out   = id_q;
  assign bus.upd_req  = upd_req;
  assign bus.irq      = ifg & ie;
endmodule
